// File: rtl/intr_arbiter_if.sv
// Signal bundle between the interrupt sources/core side and the arbiter.
// All signals are synchronous to the arbiter clock.
interface intr_arbiter_if;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_d;
  logic       rr_en;
  logic       irep;
  logic       ireq;
  logic [1:0] ivec;
  logic [1:0] src_id;
  logic       busy;
  logic [3:0] pending;
  logic [1:0] state;

  // Handshake: ireq is a level held for the hold window.
  // The core acknowledges the grant with an irep rising edge, which counts only while in SERVICE.
  modport master (
    output irq, mask_we, mask_d, rr_en, irep,
    input  ireq, ivec, src_id, busy, pending, state
  );

  modport slave (
    input  irq, mask_we, mask_d, rr_en, irep,
    output ireq, ivec, src_id, busy, pending, state
  );
endinterface

// File: rtl/intr_arbiter.sv
// Edge-triggered interrupt arbiter: fixed-priority or round-robin grant,
// a fixed-length request pulse, a wait for the core to return, and one gap cycle.
module intr_arbiter #(
  parameter int NSRC        = 4,
  parameter int HOLD_CYCLES = 3
) (
  input  logic clk,
  input  logic rst,
  intr_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_SERVICE = 2'd2;
  localparam logic [1:0] S_GAP     = 2'd3;
  localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

  logic [1:0]      state_q, state_d;
  logic [NSRC-1:0] irq_q, irq_d;
  logic            irep_q, irep_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] mask_reg_q, mask_reg_d;
  logic [1:0]      rr_ptr_q, rr_ptr_d;
  logic [1:0]      cnt_q, cnt_d;
  logic            ireq_q, ireq_d;
  logic [1:0]      ivec_q, ivec_d;
  logic [1:0]      src_q, src_d;
  logic            busy_q, busy_d;

  logic [NSRC-1:0] irq_edge;
  logic [NSRC-1:0] eligible;
  logic [NSRC-1:0] grant_clr;
  logic            irep_rise;
  logic            grant;
  logic [1:0]      base;
  logic [1:0]      idx;
  logic [1:0]      win;

  assign irq_edge  = bus.irq & ~irq_q;
  assign irep_rise = bus.irep & ~irep_q;
  assign eligible  = pending_q & ~mask_reg_q;
  assign grant     = (state_q == S_IDLE) && (|eligible);

  // Walk offsets from high to low so the offset closest to the base wins.
  always_comb begin
    base = bus.rr_en ? rr_ptr_q : 2'd0;
    win  = 2'd0;
    idx  = 2'd0;
    for (int k = NSRC - 1; k >= 0; k--) begin
      idx = base + 2'(k);
      if (eligible[idx]) win = idx;
    end
  end

  assign grant_clr = grant ? (NSRC'(1) << win) : '0;

  always_comb begin
    state_d    = state_q;
    irq_d      = bus.irq;
    irep_d     = bus.irep;
    // A new edge in the grant cycle re-arms the bit: set beats clear.
    pending_d  = (pending_q & ~grant_clr) | irq_edge;
    mask_reg_d = bus.mask_we ? bus.mask_d : mask_reg_q;
    rr_ptr_d   = rr_ptr_q;
    cnt_d      = cnt_q;
    ireq_d     = ireq_q;
    ivec_d     = ivec_q;
    src_d      = src_q;
    busy_d     = busy_q;

    case (state_q)
      S_IDLE: begin
        if (grant) begin
          state_d  = S_REQ;
          ireq_d   = 1'b1;
          ivec_d   = win[1] ? 2'b10 : 2'b01;
          src_d    = win;
          busy_d   = 1'b1;
          cnt_d    = 2'd0;
          rr_ptr_d = win + 2'd1;
        end
      end
      S_REQ: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = S_SERVICE;
          ireq_d  = 1'b0;
          cnt_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      S_SERVICE: begin
        if (irep_rise) begin
          state_d = S_GAP;
          ivec_d  = 2'b00;
        end
      end
      S_GAP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        ireq_d  = 1'b0;
        ivec_d  = 2'b00;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      irq_q      <= '0;
      irep_q     <= 1'b0;
      pending_q  <= '0;
      mask_reg_q <= '0;
      rr_ptr_q   <= 2'd0;
      cnt_q      <= 2'd0;
      ireq_q     <= 1'b0;
      ivec_q     <= 2'b00;
      src_q      <= 2'b00;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      irq_q      <= irq_d;
      irep_q     <= irep_d;
      pending_q  <= pending_d;
      mask_reg_q <= mask_reg_d;
      rr_ptr_q   <= rr_ptr_d;
      cnt_q      <= cnt_d;
      ireq_q     <= ireq_d;
      ivec_q     <= ivec_d;
      src_q      <= src_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.ireq    = ireq_q;
  assign bus.ivec    = ivec_q;
  assign bus.src_id  = src_q;
  assign bus.busy    = busy_q;
  assign bus.pending = pending_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_intr_arbiter.sv
// Directed bench for intr_arbiter: grant sequencing, priority modes, masking,
// same-source re-edge and asynchronous reset in the middle of a request.
module tb_intr_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  intr_arbiter_if bus ();

  intr_arbiter #(.NSRC(4), .HOLD_CYCLES(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called right after the grant edge; walks REQ, SERVICE, GAP and back to IDLE.
  task automatic expect_grant(input logic [1:0] src, input logic [1:0] vec);
    chk("grant_ireq", {7'd0, bus.ireq}, 8'd1);
    chk("grant_src", {6'd0, bus.src_id}, {6'd0, src});
    chk("grant_ivec", {6'd0, bus.ivec}, {6'd0, vec});
    chk("grant_busy", {7'd0, bus.busy}, 8'd1);
    tick();
    chk("hold2_ireq", {7'd0, bus.ireq}, 8'd1);
    chk("hold2_src", {6'd0, bus.src_id}, {6'd0, src});
    tick();
    chk("hold3_ireq", {7'd0, bus.ireq}, 8'd1);
    tick();
    chk("svc_ireq", {7'd0, bus.ireq}, 8'd0);
    chk("svc_busy", {7'd0, bus.busy}, 8'd1);
    chk("svc_ivec", {6'd0, bus.ivec}, {6'd0, vec});
    tick();
    chk("svc_wait_busy", {7'd0, bus.busy}, 8'd1);
    bus.irep = 1'b1;
    tick();
    chk("gap_ivec", {6'd0, bus.ivec}, 8'd0);
    chk("gap_busy", {7'd0, bus.busy}, 8'd1);
    chk("gap_ireq", {7'd0, bus.ireq}, 8'd0);
    bus.irep = 1'b0;
    tick();
    chk("idle_busy", {7'd0, bus.busy}, 8'd0);
    chk("idle_ireq", {7'd0, bus.ireq}, 8'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    bus.irq     = 4'b0000;
    bus.mask_we = 1'b0;
    bus.mask_d  = 4'b0000;
    bus.rr_en   = 1'b0;
    bus.irep    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ireq", {7'd0, bus.ireq}, 8'd0);
    chk("rst_ivec", {6'd0, bus.ivec}, 8'd0);
    chk("rst_src", {6'd0, bus.src_id}, 8'd0);
    chk("rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("rst_pending", {4'd0, bus.pending}, 8'd0);
    chk("rst_state", {6'd0, bus.state}, 8'd0);
    rst = 1'b0;

    // Single source 2 in fixed priority.
    bus.irq = 4'b0100;
    tick();
    bus.irq = 4'b0000;
    chk("single_pending", {4'd0, bus.pending}, 8'h04);
    chk("single_noreq", {7'd0, bus.ireq}, 8'd0);
    tick();
    chk("single_pending_clr", {4'd0, bus.pending}, 8'h00);
    expect_grant(2'd2, 2'b10);

    // Fixed priority with 0, 1 and 3 raised together.
    bus.irq = 4'b1011;
    tick();
    bus.irq = 4'b0000;
    chk("fixed_pending", {4'd0, bus.pending}, 8'h0b);
    tick();
    expect_grant(2'd0, 2'b01);
    tick();
    expect_grant(2'd1, 2'b01);
    tick();
    expect_grant(2'd3, 2'b10);
    tick();
    chk("fixed_done_ireq", {7'd0, bus.ireq}, 8'd0);
    chk("fixed_done_pending", {4'd0, bus.pending}, 8'h00);

    // Round-robin: grant 1 first so the pointer lands on 2, then raise all four.
    bus.rr_en = 1'b1;
    bus.irq   = 4'b0010;
    tick();
    bus.irq = 4'b0000;
    tick();
    bus.irq = 4'b1111;
    expect_grant(2'd1, 2'b01);
    chk("rr_pending_all", {4'd0, bus.pending}, 8'h0f);
    tick();
    expect_grant(2'd2, 2'b10);
    tick();
    expect_grant(2'd3, 2'b10);
    tick();
    expect_grant(2'd0, 2'b01);
    tick();
    expect_grant(2'd1, 2'b01);
    bus.irq   = 4'b0000;
    bus.rr_en = 1'b0;
    tick();
    chk("rr_done_pending", {4'd0, bus.pending}, 8'h00);

    // Masking, then a fresh irq[0] edge landing on the grant edge.
    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b0001;
    tick();
    bus.mask_we = 1'b0;
    bus.irq     = 4'b0001;
    tick();
    bus.irq = 4'b0000;
    tick();
    chk("mask_pending", {4'd0, bus.pending}, 8'h01);
    chk("mask_noreq", {7'd0, bus.ireq}, 8'd0);
    tick();
    chk("mask_noreq2", {7'd0, bus.ireq}, 8'd0);
    bus.mask_we = 1'b1;
    bus.mask_d  = 4'b0000;
    tick();
    bus.mask_we = 1'b0;
    bus.irq     = 4'b0001;
    chk("unmask_edge_noreq", {7'd0, bus.ireq}, 8'd0);
    tick();
    bus.irq = 4'b0000;
    chk("reedge_pending", {4'd0, bus.pending}, 8'h01);
    expect_grant(2'd0, 2'b01);
    tick();
    expect_grant(2'd0, 2'b01);
    chk("reedge_done_pending", {4'd0, bus.pending}, 8'h00);

    // Asynchronous reset in the second cycle of a request.
    bus.irq = 4'b1100;
    tick();
    bus.irq = 4'b0000;
    tick();
    chk("pre_rst_ireq", {7'd0, bus.ireq}, 8'd1);
    chk("pre_rst_pending", {4'd0, bus.pending}, 8'h08);
    tick();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ireq", {7'd0, bus.ireq}, 8'd0);
    chk("async_rst_busy", {7'd0, bus.busy}, 8'd0);
    chk("async_rst_pending", {4'd0, bus.pending}, 8'h00);
    chk("async_rst_src", {6'd0, bus.src_id}, 8'd0);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_ireq", {7'd0, bus.ireq}, 8'd0);
      chk("post_rst_busy", {7'd0, bus.busy}, 8'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
